// File: rtl/lcd_pkg.sv
// Shared types, character constants and the BCD-to-ASCII helper for the LCD row formatter.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONV1     = 3'd1,
    CONV2     = 3'd2,
    PACK      = 3'd3,
    WAIT_IDLE = 3'd4,
    REQ       = 3'd5
  } state_t;

  localparam int CHAR_W    = 8;
  localparam int ROW_CHARS = 16;
  localparam int ROW_W     = CHAR_W * ROW_CHARS;

  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [CHAR_W-1:0] ASCII_ZERO  = 8'h30;
  localparam logic [CHAR_W-1:0] ASCII_DOT   = 8'h2E;

  function automatic logic [CHAR_W-1:0] bcd_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/lcd_row_formatter_bin2bcd.sv
// Sequential double-dabble converter: 16-bit binary to 5 BCD digits in exactly 16 cycles.
// The start cycle performs the first shift, so the result is ready 16 edges after start.
module bin2bcd_seq (
  input  logic        clk_1MHz,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] din,
  output logic [19:0] bcd,
  output logic        done
);

  logic [19:0] bcd_r;
  logic [15:0] sh_r;
  logic [3:0]  left_r;
  logic        done_r;

  // One add-3 correction pass over all digits followed by a 1-bit shift.
  function automatic logic [19:0] dabble(input logic [19:0] b, input logic bit_in);
    logic [19:0] adj;
    adj = b;
    for (int i = 0; i < 5; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      end else begin
        adj[i*4 +: 4] = adj[i*4 +: 4];
      end
    end
    return {adj[18:0], bit_in};
  endfunction

  // Shift/add-3 engine with a remaining-shift counter.
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      bcd_r  <= 20'd0;
      sh_r   <= 16'd0;
      left_r <= 4'd0;
      done_r <= 1'b0;
    end else if (start) begin
      bcd_r  <= dabble(20'd0, din[15]);
      sh_r   <= {din[14:0], 1'b0};
      left_r <= 4'd15;
      done_r <= 1'b0;
    end else if (left_r != 4'd0) begin
      bcd_r  <= dabble(bcd_r, sh_r[15]);
      sh_r   <= {sh_r[14:0], 1'b0};
      left_r <= left_r - 4'd1;
      done_r <= (left_r == 4'd1);
    end else begin
      done_r <= done_r;
    end
  end

  assign bcd  = bcd_r;
  assign done = done_r;

endmodule

// File: rtl/lcd_row_formatter.sv
// Converts two 16-bit readings into two labelled ASCII rows and requests one LCD refresh.
// Optional macro LCD_DECIMAL_POINT_EN shows each value as tenths ("dddd.d").
module lcd_row_formatter
  import lcd_pkg::*;
#(
  parameter logic [47:0] LABEL1      = "TEMP: ",
  parameter logic [47:0] LABEL2      = "HUMI: ",
  parameter bit          BLANK_ZEROS = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic             clk_1MHz,
  input  logic             rst,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [15:0]      val1,
  input  logic [15:0]      val2,
  input  logic             busy,
  output logic             lcd_ena,
  output logic [ROW_W-1:0] row1,
  output logic [ROW_W-1:0] row2,
  output logic             ack_err
);

`ifdef LCD_DECIMAL_POINT_EN
  localparam int LSD_IDX = 1;
`else
  localparam int LSD_IDX = 0;
`endif
  localparam logic [9:0]       TMO_LAST   = 10'(ACK_TIMEOUT - 32'd1);
  localparam logic [ROW_W-1:0] ROW_BLANK  = {ROW_CHARS{ASCII_SPACE}};

  state_t           state_r, state_s;
  logic [15:0]      val1_r, val1_s, val2_r, val2_s;
  logic [3:0]       conv_cnt_r, conv_cnt_s;
  logic [19:0]      bcd1_r, bcd1_s;
  logic [9:0]       tmo_cnt_r, tmo_cnt_s;
  logic             upd_ready_r, upd_ready_s;
  logic             lcd_ena_r, lcd_ena_s;
  logic             ack_err_r, ack_err_s;
  logic [ROW_W-1:0] row1_r, row1_s, row2_r, row2_s;
  logic             bcd_start_s;
  logic [15:0]      bcd_din_s;
  logic [19:0]      bcd_out_s;
  logic             bcd_done_s;

  // Digit at index LSD_IDX is the least-significant integer digit and is never blanked.
  function automatic logic [ROW_W-1:0] pack_row(input logic [47:0] label, input logic [19:0] bcd);
    logic [CHAR_W-1:0] ch [5];
    logic              lead;
    lead = BLANK_ZEROS;
    for (int i = 4; i >= 0; i--) begin
      if (lead && (i > LSD_IDX) && (bcd[i*4 +: 4] == 4'd0)) begin
        ch[i] = ASCII_SPACE;
      end else begin
        lead  = 1'b0;
        ch[i] = bcd_to_ascii(bcd[i*4 +: 4]);
      end
    end
`ifdef LCD_DECIMAL_POINT_EN
    return {label, ch[4], ch[3], ch[2], ch[1], ASCII_DOT, ch[0], {4{ASCII_SPACE}}};
`else
    return {label, ch[4], ch[3], ch[2], ch[1], ch[0], {5{ASCII_SPACE}}};
`endif
  endfunction

  bin2bcd_seq u_bin2bcd (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .start    (bcd_start_s),
    .din      (bcd_din_s),
    .bcd      (bcd_out_s),
    .done     (bcd_done_s)
  );

  // Next-state and next-output logic for the whole update/refresh sequence.
  always_comb begin
    state_s     = state_r;
    val1_s      = val1_r;
    val2_s      = val2_r;
    conv_cnt_s  = conv_cnt_r;
    bcd1_s      = bcd1_r;
    tmo_cnt_s   = tmo_cnt_r;
    upd_ready_s = upd_ready_r;
    lcd_ena_s   = lcd_ena_r;
    ack_err_s   = 1'b0;
    row1_s      = row1_r;
    row2_s      = row2_r;
    bcd_start_s = 1'b0;
    bcd_din_s   = val1_r;

    case (state_r)
      IDLE: begin
        if (upd_valid && upd_ready_r) begin
          val1_s      = val1;
          val2_s      = val2;
          upd_ready_s = 1'b0;
          conv_cnt_s  = 4'd0;
          state_s     = CONV1;
        end else begin
          state_s = IDLE;
        end
      end
      CONV1: begin
        bcd_din_s   = val1_r;
        bcd_start_s = (conv_cnt_r == 4'd0);
        conv_cnt_s  = conv_cnt_r + 4'd1;
        if (conv_cnt_r == 4'd15) begin
          state_s = CONV2;
        end else begin
          state_s = CONV1;
        end
      end
      CONV2: begin
        // The converter is restarted for val2 on the same edge that its val1 result is kept.
        bcd_din_s   = val2_r;
        bcd_start_s = (conv_cnt_r == 4'd0);
        conv_cnt_s  = conv_cnt_r + 4'd1;
        if ((conv_cnt_r == 4'd0) && bcd_done_s) begin
          bcd1_s = bcd_out_s;
        end else begin
          bcd1_s = bcd1_r;
        end
        if (conv_cnt_r == 4'd15) begin
          state_s = PACK;
        end else begin
          state_s = CONV2;
        end
      end
      PACK: begin
        row1_s  = pack_row(LABEL1, bcd1_r);
        row2_s  = pack_row(LABEL2, bcd_out_s);
        state_s = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!busy) begin
          lcd_ena_s = 1'b1;
          tmo_cnt_s = 10'd0;
          state_s   = REQ;
        end else begin
          state_s = WAIT_IDLE;
        end
      end
      REQ: begin
        if (busy) begin
          lcd_ena_s   = 1'b0;
          upd_ready_s = 1'b1;
          state_s     = IDLE;
        end else if (tmo_cnt_r == TMO_LAST) begin
          lcd_ena_s   = 1'b0;
          ack_err_s   = 1'b1;
          upd_ready_s = 1'b1;
          state_s     = IDLE;
        end else begin
          tmo_cnt_s = tmo_cnt_r + 10'd1;
          state_s   = REQ;
        end
      end
      default: begin
        lcd_ena_s   = 1'b0;
        upd_ready_s = 1'b1;
        state_s     = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns rows to spaces immediately.
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state_r     <= IDLE;
      val1_r      <= 16'd0;
      val2_r      <= 16'd0;
      conv_cnt_r  <= 4'd0;
      bcd1_r      <= 20'd0;
      tmo_cnt_r   <= 10'd0;
      upd_ready_r <= 1'b1;
      lcd_ena_r   <= 1'b0;
      ack_err_r   <= 1'b0;
      row1_r      <= ROW_BLANK;
      row2_r      <= ROW_BLANK;
    end else begin
      state_r     <= state_s;
      val1_r      <= val1_s;
      val2_r      <= val2_s;
      conv_cnt_r  <= conv_cnt_s;
      bcd1_r      <= bcd1_s;
      tmo_cnt_r   <= tmo_cnt_s;
      upd_ready_r <= upd_ready_s;
      lcd_ena_r   <= lcd_ena_s;
      ack_err_r   <= ack_err_s;
      row1_r      <= row1_s;
      row2_r      <= row2_s;
    end
  end

  assign upd_ready = upd_ready_r;
  assign lcd_ena   = lcd_ena_r;
  assign ack_err   = ack_err_r;
  assign row1      = row1_r;
  assign row2      = row2_r;

endmodule

// File: tb/tb_lcd_row_formatter.sv
// Self-checking bench for lcd_row_formatter with a value-based row model.
// Honours LCD_DECIMAL_POINT_EN in the model when the design is built with it.
module tb_lcd_row_formatter;

  logic         clk_1MHz = 1'b0;
  logic         rst = 1'b1;
  logic         upd_valid = 1'b0;
  logic         upd_ready;
  logic [15:0]  val1 = 16'd0;
  logic [15:0]  val2 = 16'd0;
  logic         busy = 1'b0;
  logic         lcd_ena;
  logic [127:0] row1;
  logic [127:0] row2;
  logic         ack_err;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] SPACES = {16{8'h20}};
  localparam logic [47:0]  LBL1   = "TEMP: ";
  localparam logic [47:0]  LBL2   = "HUMI: ";

  always #5 clk_1MHz = ~clk_1MHz;

  lcd_row_formatter dut (
    .clk_1MHz  (clk_1MHz),
    .rst       (rst),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .val1      (val1),
    .val2      (val2),
    .busy      (busy),
    .lcd_ena   (lcd_ena),
    .row1      (row1),
    .row2      (row2),
    .ack_err   (ack_err)
  );

  // Expected row from the numeric value: print digits, blank those above the value's magnitude.
  function automatic logic [127:0] model_row(input logic [47:0] label, input int v);
    logic [127:0] r;
    int p;
    int ip;
    r = {label, {10{8'h20}}};
`ifdef LCD_DECIMAL_POINT_EN
    ip = v / 10;
    p  = 1000;
    for (int k = 0; k < 4; k++) begin
      if (k == 3 || ip >= p) r[79-8*k -: 8] = 8'h30 + 8'((ip / p) % 10);
      p = p / 10;
    end
    r[47:40] = 8'h2E;
    r[39:32] = 8'h30 + 8'(v % 10);
`else
    ip = v;
    p  = 10000;
    for (int k = 0; k < 5; k++) begin
      if (k == 4 || ip >= p) r[79-8*k -: 8] = 8'h30 + 8'((ip / p) % 10);
      p = p / 10;
    end
`endif
    return r;
  endfunction

  // Handshake one update; lat = edges from the transfer edge until lcd_ena is seen high.
  task automatic run_txn(input logic [15:0] v1, input logic [15:0] v2,
                         output int lat, output logic rdy_after, output logic [127:0] pre_row1);
    @(negedge clk_1MHz);
    val1 = v1; val2 = v2; upd_valid = 1'b1;
    @(negedge clk_1MHz);
    upd_valid = 1'b0;
    rdy_after = upd_ready;
    pre_row1  = row1;
    lat = 0;
    while (lcd_ena !== 1'b1 && lat < 200) begin
      @(negedge clk_1MHz);
      lat++;
      if (lat == 32) pre_row1 = row1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; upd_valid = 1'b0; busy = 1'b0;
    repeat (3) @(negedge clk_1MHz);
    rst = 1'b0;
    @(negedge clk_1MHz);
    total++; if (row1 !== SPACES) begin bad++; $display("FAIL reset_row1 got=%h exp=%h", row1, SPACES); end
    total++; if (row2 !== SPACES) begin bad++; $display("FAIL reset_row2 got=%h exp=%h", row2, SPACES); end
    total++; if (lcd_ena !== 1'b0) begin bad++; $display("FAIL reset_lcd_ena got=%b exp=0", lcd_ena); end
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL reset_upd_ready got=%b exp=1", upd_ready); end
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err got=%b exp=0", ack_err); end
  endtask

  task automatic test_basic();
    int lat;
    logic rdy;
    logic [127:0] pre;
    logic [127:0] lit1;
    logic [127:0] lit2;
    busy = 1'b0;
    run_txn(16'd0, 16'd65535, lat, rdy, pre);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL basic_ready_drop got=%b exp=0", rdy); end
    total++; if (lat !== 34) begin bad++; $display("FAIL basic_latency got=%0d exp=34", lat); end
    total++; if (pre !== SPACES) begin bad++; $display("FAIL basic_row_before_pack got=%h exp=%h", pre, SPACES); end
    total++; if (row1 !== model_row(LBL1, 0)) begin bad++; $display("FAIL basic_row1 got=%h exp=%h", row1, model_row(LBL1, 0)); end
    total++; if (row2 !== model_row(LBL2, 65535)) begin bad++; $display("FAIL basic_row2 got=%h exp=%h", row2, model_row(LBL2, 65535)); end
`ifndef LCD_DECIMAL_POINT_EN
    lit1 = "TEMP:     0     ";
    lit2 = "HUMI: 65535     ";
    total++; if (row1 !== lit1) begin bad++; $display("FAIL basic_row1_text got=%h exp=%h", row1, lit1); end
    total++; if (row2 !== lit2) begin bad++; $display("FAIL basic_row2_text got=%h exp=%h", row2, lit2); end
`endif
    repeat (2) @(negedge clk_1MHz);
    total++; if (lcd_ena !== 1'b1) begin bad++; $display("FAIL basic_ena_hold got=%b exp=1", lcd_ena); end
    @(negedge clk_1MHz);
    busy = 1'b1;
    @(negedge clk_1MHz);
    busy = 1'b0;
    total++; if (lcd_ena !== 1'b0) begin bad++; $display("FAIL basic_ena_fall got=%b exp=0", lcd_ena); end
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b exp=1", upd_ready); end
    // Decimal-point example values (plain integers in the default build)
    run_txn(16'd253, 16'd7, lat, rdy, pre);
    total++; if (row1 !== model_row(LBL1, 253)) begin bad++; $display("FAIL dp_row1 got=%h exp=%h", row1, model_row(LBL1, 253)); end
    total++; if (row2 !== model_row(LBL2, 7)) begin bad++; $display("FAIL dp_row2 got=%h exp=%h", row2, model_row(LBL2, 7)); end
`ifdef LCD_DECIMAL_POINT_EN
    lit1 = "TEMP:   25.3    ";
    lit2 = "HUMI:    0.7    ";
    total++; if (row1 !== lit1) begin bad++; $display("FAIL dp_row1_text got=%h exp=%h", row1, lit1); end
    total++; if (row2 !== lit2) begin bad++; $display("FAIL dp_row2_text got=%h exp=%h", row2, lit2); end
`endif
    busy = 1'b1;
    @(negedge clk_1MHz);
    busy = 1'b0;
    total++; if (lcd_ena !== 1'b0) begin bad++; $display("FAIL dp_ena_fall got=%b exp=0", lcd_ena); end
  endtask

  task automatic test_random();
    int lat;
    int d;
    logic rdy;
    logic [127:0] pre;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] edges [8];
    edges = '{16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000, 16'd9999, 16'd10000};
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        a = edges[i];
        b = edges[7-i];
      end else begin
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
      end
      busy = 1'b0;
      run_txn(a, b, lat, rdy, pre);
      total++; if (lat !== 34) begin bad++; $display("FAIL rand_latency[%0d] got=%0d exp=34", i, lat); end
      total++; if (row1 !== model_row(LBL1, int'(a))) begin bad++; $display("FAIL rand_row1[%0d] v=%0d got=%h exp=%h", i, a, row1, model_row(LBL1, int'(a))); end
      total++; if (row2 !== model_row(LBL2, int'(b))) begin bad++; $display("FAIL rand_row2[%0d] v=%0d got=%h exp=%h", i, b, row2, model_row(LBL2, int'(b))); end
      d = $urandom_range(0, 4);
      repeat (d) @(negedge clk_1MHz);
      total++; if (lcd_ena !== 1'b1) begin bad++; $display("FAIL rand_ena_hold[%0d] got=%b exp=1", i, lcd_ena); end
      busy = 1'b1;
      @(negedge clk_1MHz);
      busy = 1'b0;
      total++; if (lcd_ena !== 1'b0) begin bad++; $display("FAIL rand_ena_fall[%0d] got=%b exp=0", i, lcd_ena); end
    end
  endtask

  task automatic test_busy_wait();
    logic [127:0] e1;
    logic [127:0] e2;
    e1 = model_row(LBL1, 1234);
    e2 = model_row(LBL2, 4321);
    busy = 1'b1;
    @(negedge clk_1MHz);
    val1 = 16'd1234; val2 = 16'd4321; upd_valid = 1'b1;
    @(negedge clk_1MHz);
    upd_valid = 1'b0;
    repeat (33) @(negedge clk_1MHz);
    total++; if (row1 !== e1) begin bad++; $display("FAIL wait_row1 got=%h exp=%h", row1, e1); end
    total++; if (row2 !== e2) begin bad++; $display("FAIL wait_row2 got=%h exp=%h", row2, e2); end
    val1 = 16'd7; val2 = 16'd8; upd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_1MHz);
      total++; if (lcd_ena !== 1'b0) begin bad++; $display("FAIL wait_ena_low[%0d] got=%b exp=0", k, lcd_ena); end
      total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL wait_ready_low[%0d] got=%b exp=0", k, upd_ready); end
    end
    upd_valid = 1'b0;
    busy = 1'b0;
    @(negedge clk_1MHz);
    total++; if (lcd_ena !== 1'b1) begin bad++; $display("FAIL wait_ena_rise got=%b exp=1", lcd_ena); end
    busy = 1'b1;
    @(negedge clk_1MHz);
    busy = 1'b0;
    total++; if (lcd_ena !== 1'b0) begin bad++; $display("FAIL wait_ena_fall got=%b exp=0", lcd_ena); end
    total++; if (row1 !== e1) begin bad++; $display("FAIL wait_row1_kept got=%h exp=%h", row1, e1); end
    total++; if (row2 !== e2) begin bad++; $display("FAIL wait_row2_kept got=%h exp=%h", row2, e2); end
  endtask

  task automatic test_timeout();
    int lat;
    int hi;
    logic rdy;
    logic [127:0] pre;
    busy = 1'b0;
    run_txn(16'd42, 16'd500, lat, rdy, pre);
    total++; if (lat !== 34) begin bad++; $display("FAIL tmo_latency got=%0d exp=34", lat); end
    hi = 1;
    while (hi < 2000) begin
      @(negedge clk_1MHz);
      if (lcd_ena === 1'b1) hi++;
      else break;
    end
    total++; if (hi !== 1023) begin bad++; $display("FAIL tmo_ena_cycles got=%0d exp=1023", hi); end
    total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL tmo_ack_err got=%b exp=1", ack_err); end
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL tmo_ready got=%b exp=1", upd_ready); end
    @(negedge clk_1MHz);
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL tmo_ack_err_pulse got=%b exp=0", ack_err); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic rdy;
    logic [127:0] pre;
    logic [15:0] a;
    logic [15:0] b;
    busy = 1'b0;
    @(negedge clk_1MHz);
    val1 = 16'd111; val2 = 16'd222; upd_valid = 1'b1;
    @(negedge clk_1MHz);
    upd_valid = 1'b0;
    repeat (20) @(negedge clk_1MHz);
    total++; if (row1 === SPACES) begin bad++; $display("FAIL mid_row1_prev got=%h exp=non-blank", row1); end
    rst = 1'b1;
    @(negedge clk_1MHz);
    rst = 1'b0;
    total++; if (row1 !== SPACES) begin bad++; $display("FAIL mid_row1 got=%h exp=%h", row1, SPACES); end
    total++; if (row2 !== SPACES) begin bad++; $display("FAIL mid_row2 got=%h exp=%h", row2, SPACES); end
    total++; if (lcd_ena !== 1'b0) begin bad++; $display("FAIL mid_lcd_ena got=%b exp=0", lcd_ena); end
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL mid_upd_ready got=%b exp=1", upd_ready); end
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
    run_txn(a, b, lat, rdy, pre);
    total++; if (lat !== 34) begin bad++; $display("FAIL mid_latency got=%0d exp=34", lat); end
    total++; if (row1 !== model_row(LBL1, int'(a))) begin bad++; $display("FAIL mid_fresh_row1 got=%h exp=%h", row1, model_row(LBL1, int'(a))); end
    total++; if (row2 !== model_row(LBL2, int'(b))) begin bad++; $display("FAIL mid_fresh_row2 got=%h exp=%h", row2, model_row(LBL2, int'(b))); end
    busy = 1'b1;
    @(negedge clk_1MHz);
    busy = 1'b0;
    total++; if (lcd_ena !== 1'b0) begin bad++; $display("FAIL mid_ena_fall got=%b exp=0", lcd_ena); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_busy_wait();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
